// File: rtl/proc_ext_pkg.sv
// Shared constants for proc_ext: opcodes, bus selects, Tstep states, branch conditions.
// Purely declarative; no timing or flow control of its own.
package proc_ext_pkg;

    localparam logic [2:0] mv_  = 3'b000;
    localparam logic [2:0] mvt_ = 3'b001;
    localparam logic [2:0] add_ = 3'b010;
    localparam logic [2:0] sub_ = 3'b011;
    localparam logic [2:0] ld_  = 3'b100;
    localparam logic [2:0] st_  = 3'b101;
    localparam logic [2:0] and_ = 3'b110;
    localparam logic [2:0] b_   = 3'b111;

    // Codes 0-7 select R0-R7; anything not listed puts zero on the bus.
    localparam logic [3:0] SEL_G    = 4'd8;
    localparam logic [3:0] SEL_DIN  = 4'd9;
    localparam logic [3:0] SEL_IMM  = 4'd10;
    localparam logic [3:0] SEL_MVT  = 4'd11;
    localparam logic [3:0] SEL_SEXT = 4'd12;
    localparam logic [3:0] SEL_NONE = 4'd15;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_CC = 3'b011;
    localparam logic [2:0] COND_CS = 3'b100;
    localparam logic [2:0] COND_PL = 3'b101;
    localparam logic [2:0] COND_MI = 3'b110;
    localparam logic [2:0] COND_NV = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;

    function automatic logic cond_true(input logic [2:0] cond, input logic n,
                                       input logic z, input logic c);
        logic res;
        case (cond)
            COND_AL: res = 1'b1;
            COND_EQ: res = z;
            COND_NE: res = !z;
            COND_CC: res = !c;
            COND_CS: res = c;
            COND_PL: res = !n;
            COND_MI: res = n;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/proc_ext_alu.sv
// DW-wide add/sub/and with carry (add) or no-borrow (sub), plus N and Z; combinational.
// No state, no flow control.
import proc_ext_pkg::*;

module proc_ext_alu #(
    parameter int DW = 16
) (
    input  logic [1:0]    i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_res,
    output logic          o_n,
    output logic          o_z,
    output logic          o_c
);
    logic [DW:0] w_sum;

    // Subtract as a + ~b + 1 so the carry out is exactly the unsigned a >= b test.
    always_comb begin
        case (i_op)
            ALU_SUB: w_sum = {1'b0, i_a} + {1'b0, ~i_b} + {{DW{1'b0}}, 1'b1};
            ALU_AND: w_sum = {1'b0, i_a & i_b};
            default: w_sum = {1'b0, i_a} + {1'b0, i_b};
        endcase
    end

    assign o_res = w_sum[DW-1:0];
    assign o_c   = w_sum[DW];
    assign o_n   = w_sum[DW-1];
    assign o_z   = (w_sum[DW-1:0] == '0);
endmodule

// File: rtl/proc_ext_lib.sv
// Reused datapath primitives: enable register, 3-to-8 decoder, loadable PC counter.
// Registers update one cycle after enable; synchronous active-high reset, no backpressure.
module regn #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_q <= '0;
        else if (i_en)
            o_q <= i_d;
    end
endmodule

module dec3to8 (
    input  logic [2:0] i_w,
    input  logic       i_en,
    output logic [7:0] o_y
);
    always_comb begin
        o_y = 8'd0;
        if (i_en)
            o_y[i_w] = 1'b1;
    end
endmodule

module pc_count #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ld,
    input  logic         i_inc,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    // A register write to the PC overrides the fetch increment.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_q <= '0;
        else if (i_ld)
            o_q <= i_d;
        else if (i_inc)
            o_q <= o_q + {{(W-1){1'b0}}, 1'b1};
    end
endmodule

// File: rtl/proc_ext.sv
// Multicycle bus processor, 4/6 cycles per instruction; Run gates fetch in T0 only.
// PROC_EXT_BRANCH_EN builds the b{cond} datapath; otherwise opcode 111 is a 4-cycle no-op.
import proc_ext_pkg::*;

module proc_ext #(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    output logic [DW-1:0] DOUT,
    output logic [AW-1:0] ADDR,
    output logic          W,
    output logic          Done,
    output logic [2:0]    Flags
);
    logic [2:0]    r_tstep, w_next;
    logic          r_w;
    logic [15:0]   w_ir;
    logic [DW-1:0] w_r [8];
    logic [DW-1:0] w_a, w_g, w_bus, w_alu_res;
    logic [7:0]    w_r_en;
    logic [3:0]    w_sel;
    logic [1:0]    w_alu_op;
    logic          w_ir_en, w_wr_en, w_a_en, w_g_en, w_addr_en, w_dout_en;
    logic          w_w_d, w_pc_inc, w_done, w_flag_en;
    logic          w_n, w_z, w_c;

    logic [2:0] w_op, w_rx, w_ry;
    logic       w_imm;
    logic [8:0] w_d;
    assign w_op  = w_ir[15:13];
    assign w_imm = w_ir[12];
    assign w_rx  = w_ir[11:9];
    assign w_ry  = w_ir[2:0];
    assign w_d   = w_ir[8:0];

    logic w_is_alu;
    assign w_is_alu = (w_op == add_) || (w_op == sub_) || (w_op == and_);

`ifdef PROC_EXT_BRANCH_EN
    logic w_taken;
    assign w_taken = cond_true(w_rx, Flags[2], Flags[1], Flags[0]);
`endif

    always_comb begin
        w_next    = r_tstep;
        w_sel     = SEL_NONE;
        w_alu_op  = ALU_ADD;
        w_ir_en   = 1'b0;
        w_wr_en   = 1'b0;
        w_a_en    = 1'b0;
        w_g_en    = 1'b0;
        w_addr_en = 1'b0;
        w_dout_en = 1'b0;
        w_w_d     = 1'b0;
        w_pc_inc  = 1'b0;
        w_done    = 1'b0;
        case (w_op)
            sub_:    w_alu_op = ALU_SUB;
            and_:    w_alu_op = ALU_AND;
            default: w_alu_op = ALU_ADD;
        endcase
        case (r_tstep)
            T0: begin
                w_sel     = 4'd7;
                w_addr_en = 1'b1;
                if (Run) begin
                    w_pc_inc = 1'b1;
                    w_next   = T1;
                end
            end
            T1: w_next = T2;
            T2: begin
                w_ir_en = 1'b1;
                w_next  = T3;
            end
            T3: begin
                w_next = T4;
                case (w_op)
                    mv_: begin
                        w_sel   = w_imm ? SEL_IMM : {1'b0, w_ry};
                        w_wr_en = 1'b1;
                        w_done  = 1'b1;
                        w_next  = T0;
                    end
                    mvt_: begin
                        w_sel   = SEL_MVT;
                        w_wr_en = 1'b1;
                        w_done  = 1'b1;
                        w_next  = T0;
                    end
                    ld_, st_: begin
                        w_sel     = {1'b0, w_ry};
                        w_addr_en = 1'b1;
                    end
                    b_: begin
`ifdef PROC_EXT_BRANCH_EN
                        if (w_taken) begin
                            w_sel  = 4'd7;
                            w_a_en = 1'b1;
                        end else begin
                            w_done = 1'b1;
                            w_next = T0;
                        end
`else
                        w_done = 1'b1;
                        w_next = T0;
`endif
                    end
                    default: begin
                        w_sel  = {1'b0, w_rx};
                        w_a_en = 1'b1;
                    end
                endcase
            end
            T4: begin
                w_next = T5;
                if (w_is_alu) begin
                    w_sel  = w_imm ? SEL_IMM : {1'b0, w_ry};
                    w_g_en = 1'b1;
                end else if (w_op == st_) begin
                    w_sel     = {1'b0, w_rx};
                    w_dout_en = 1'b1;
                    w_w_d     = 1'b1;
`ifdef PROC_EXT_BRANCH_EN
                end else if (w_op == b_) begin
                    w_sel  = SEL_SEXT;
                    w_g_en = 1'b1;
`endif
                end
            end
            T5: begin
                w_done = 1'b1;
                w_next = T0;
                if (w_is_alu) begin
                    w_sel   = SEL_G;
                    w_wr_en = 1'b1;
                end else if (w_op == ld_) begin
                    w_sel   = SEL_DIN;
                    w_wr_en = 1'b1;
`ifdef PROC_EXT_BRANCH_EN
                end else if (w_op == b_) begin
                    w_sel   = SEL_G;
                    w_wr_en = 1'b1;
`endif
                end
            end
            default: w_next = T0;
        endcase
        // Reset cycle: nothing loads, no strobes escape, FSM restarts at T0.
        if (Reset) begin
            w_next    = T0;
            w_ir_en   = 1'b0;
            w_wr_en   = 1'b0;
            w_a_en    = 1'b0;
            w_g_en    = 1'b0;
            w_addr_en = 1'b0;
            w_dout_en = 1'b0;
            w_w_d     = 1'b0;
            w_pc_inc  = 1'b0;
            w_done    = 1'b0;
        end
    end

    assign w_flag_en = w_g_en && w_is_alu;

    always_comb begin
        case (w_sel)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd4, 4'd5, 4'd6, 4'd7: w_bus = w_r[w_sel[2:0]];
            SEL_G:    w_bus = w_g;
            SEL_DIN:  w_bus = DIN;
            SEL_IMM:  w_bus = {{(DW-9){1'b0}}, w_d};
            SEL_MVT:  w_bus = {w_d[7:0], {(DW-8){1'b0}}};
`ifdef PROC_EXT_BRANCH_EN
            SEL_SEXT: w_bus = {{(DW-9){w_d[8]}}, w_d};
`endif
            default:  w_bus = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_tstep <= T0;
            r_w     <= 1'b0;
        end else begin
            r_tstep <= w_next;
            r_w     <= w_w_d;
        end
    end

    dec3to8 u_dec (
        .i_w  ((w_op == b_) ? 3'd7 : w_rx),
        .i_en (w_wr_en),
        .o_y  (w_r_en)
    );

    for (genvar gi = 0; gi < 7; gi++) begin : g_reg
        regn #(.W(DW)) u_r (
            .i_clk (Clock), .i_rst (Reset), .i_en (w_r_en[gi]),
            .i_d   (w_bus), .o_q   (w_r[gi])
        );
    end

    pc_count #(.W(DW)) u_pc (
        .i_clk (Clock), .i_rst (Reset), .i_ld (w_r_en[7]),
        .i_inc (w_pc_inc), .i_d (w_bus), .o_q (w_r[7])
    );

    regn #(.W(16)) u_ir (
        .i_clk (Clock), .i_rst (Reset), .i_en (w_ir_en),
        .i_d   (DIN[15:0]), .o_q (w_ir)
    );

    regn #(.W(DW)) u_a (
        .i_clk (Clock), .i_rst (Reset), .i_en (w_a_en), .i_d (w_bus), .o_q (w_a)
    );

    proc_ext_alu #(.DW(DW)) u_alu (
        .i_op (w_alu_op), .i_a (w_a), .i_b (w_bus),
        .o_res (w_alu_res), .o_n (w_n), .o_z (w_z), .o_c (w_c)
    );

    regn #(.W(DW)) u_g (
        .i_clk (Clock), .i_rst (Reset), .i_en (w_g_en), .i_d (w_alu_res), .o_q (w_g)
    );

    regn #(.W(3)) u_flags (
        .i_clk (Clock), .i_rst (Reset), .i_en (w_flag_en),
        .i_d   ({w_n, w_z, w_c}), .o_q (Flags)
    );

    regn #(.W(AW)) u_addr (
        .i_clk (Clock), .i_rst (Reset), .i_en (w_addr_en),
        .i_d   (w_bus[AW-1:0]), .o_q (ADDR)
    );

    regn #(.W(DW)) u_dout (
        .i_clk (Clock), .i_rst (Reset), .i_en (w_dout_en), .i_d (w_bus), .o_q (DOUT)
    );

    assign W    = r_w;
    assign Done = w_done;
endmodule

// File: tb/tb_proc_ext.sv
// Directed bench for proc_ext: straight-line instruction table, branch loop, reset during store.
import proc_ext_pkg::*;

module tb_proc_ext;
    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [AW-1:0] addr;
    logic          w, done;
    logic [2:0]    flags;

    logic [DW-1:0] mem [256];
    logic          ld_en   = 1'b0;
    logic [7:0]    ld_addr = 8'd0;
    logic [DW-1:0] ld_dat  = '0;

    int errors = 0;
    int checks = 0;

    proc_ext #(.DW(DW), .AW(AW)) dut (
        .Clock (clk), .Reset (rst), .Run (run), .DIN (din),
        .DOUT (dout), .ADDR (addr), .W (w), .Done (done), .Flags (flags)
    );

    always #5 clk = ~clk;

    // Synchronous memory: one-cycle read latency, write while W is high.
    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_dat;
        else if (w)
            mem[addr[7:0]] <= dout;
        din <= mem[addr[7:0]];
    end

    typedef struct {
        logic [15:0] ins;
        int          cyc;
        int          ri;
        logic [15:0] rv;
        logic [2:0]  fl;
        int          wc;
    } vec_t;

    vec_t v[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic m,
                                        input logic [2:0] x, input logic [8:0] d);
        return {op, m, x, d};
    endfunction

    function automatic logic [DW-1:0] get_reg(input int idx);
        case (idx)
            0: return dut.w_r[0];
            1: return dut.w_r[1];
            2: return dut.w_r[2];
            3: return dut.w_r[3];
            4: return dut.w_r[4];
            5: return dut.w_r[5];
            6: return dut.w_r[6];
            default: return dut.w_r[7];
        endcase
    endfunction

    task automatic put(input logic [7:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_dat = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Starts at the negedge of an instruction's T0; returns at the negedge of the next T0.
    task automatic step(output int cyc, output int wcnt,
                        output logic [AW-1:0] waddr, output logic [DW-1:0] wdat);
        bit got;
        got = 1'b0; cyc = 0; wcnt = 0; waddr = '0; wdat = '0;
        while (!got && cyc < 20) begin
            cyc++;
            if (w) begin
                wcnt++; waddr = addr; wdat = dout;
            end
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    initial begin
        int cyc, wc;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        int exp_loop[$];
        bit saw_w;

        v[0]  = '{enc(mv_,  1, 0, 9'h005), 4, 0, 16'h0005, 3'b000, 0};
        v[1]  = '{enc(mvt_, 1, 1, 9'h012), 4, 1, 16'h1200, 3'b000, 0};
        v[2]  = '{enc(add_, 0, 0, 9'h001), 6, 0, 16'h1205, 3'b000, 0};
        v[3]  = '{enc(mv_,  1, 2, 9'h000), 4, 2, 16'h0000, 3'b000, 0};
        v[4]  = '{enc(sub_, 1, 2, 9'h001), 6, 2, 16'hFFFF, 3'b100, 0};
        v[5]  = '{enc(add_, 1, 2, 9'h001), 6, 2, 16'h0000, 3'b011, 0};
        v[6]  = '{enc(and_, 1, 0, 9'h0FF), 6, 0, 16'h0005, 3'b000, 0};
        v[7]  = '{enc(and_, 1, 1, 9'h00F), 6, 1, 16'h0000, 3'b010, 0};
        v[8]  = '{enc(mv_,  1, 3, 9'h1AB), 4, 3, 16'h01AB, 3'b010, 0};
        v[9]  = '{enc(mv_,  1, 4, 9'h040), 4, 4, 16'h0040, 3'b010, 0};
        v[10] = '{enc(st_,  0, 3, 9'h004), 6, 3, 16'h01AB, 3'b010, 1};
        v[11] = '{enc(ld_,  0, 5, 9'h004), 6, 5, 16'h01AB, 3'b010, 0};
        v[12] = '{enc(mv_,  0, 6, 9'h005), 4, 6, 16'h01AB, 3'b010, 0};
        v[13] = '{enc(sub_, 0, 5, 9'h006), 6, 5, 16'h0000, 3'b011, 0};

        // Clear memory and load the straight-line program while held in reset.
        @(negedge clk);
        for (int i = 0; i < 256; i++) put(i[7:0], 16'h0000);
        for (int i = 0; i < 14; i++) put(i[7:0], v[i].ins);

        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_w",     {31'd0, w}, 32'd0);
        chk("rst_addr",  {16'd0, addr}, 32'd0);
        chk("rst_dout",  {16'd0, dout}, 32'd0);
        chk("rst_flags", {29'd0, flags}, 32'd0);
        chk("rst_pc",    {16'd0, get_reg(7)}, 32'd0);
        chk("rst_r0",    {16'd0, get_reg(0)}, 32'd0);
        chk("rst_tstep", {29'd0, dut.r_tstep}, {29'd0, T0});

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_pc",    {16'd0, get_reg(7)}, 32'd0);
        chk("idle_tstep", {29'd0, dut.r_tstep}, {29'd0, T0});
        chk("idle_done",  {31'd0, done}, 32'd0);

        run = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step(cyc, wc, wa, wd);
            chk($sformatf("v%0d_cycles", i), cyc, v[i].cyc);
            chk($sformatf("v%0d_reg", i), {16'd0, get_reg(v[i].ri)}, {16'd0, v[i].rv});
            chk($sformatf("v%0d_flags", i), {29'd0, flags}, {29'd0, v[i].fl});
            chk($sformatf("v%0d_pc", i), {16'd0, get_reg(7)}, i + 1);
            chk($sformatf("v%0d_wcount", i), wc, v[i].wc);
            if (v[i].wc != 0) begin
                chk($sformatf("v%0d_waddr", i), {16'd0, wa}, 32'h40);
                chk($sformatf("v%0d_wdat", i), {16'd0, wd}, 32'h1AB);
            end
        end
        chk("mem_store", {16'd0, mem[8'h40]}, 32'h1AB);
        run = 1'b0;

        // Countdown loop: mv r0,#3; sub r0,#1; bne -2.
        rst = 1'b1;
        @(negedge clk);
        put(8'd0, enc(mv_,  1, 0, 9'h003));
        put(8'd1, enc(sub_, 1, 0, 9'h001));
        put(8'd2, enc(b_,   0, COND_NE, 9'h1FE));
        put(8'd3, 16'h0000);
        rst = 1'b0;
        run = 1'b1;
`ifdef PROC_EXT_BRANCH_EN
        exp_loop = '{4, 6, 6, 6, 6, 6, 4};
`else
        exp_loop = '{4, 6, 4};
`endif
        foreach (exp_loop[i]) begin
            step(cyc, wc, wa, wd);
            chk($sformatf("loop%0d_cycles", i), cyc, exp_loop[i]);
        end
        chk("loop_pc", {16'd0, get_reg(7)}, 32'd3);
`ifdef PROC_EXT_BRANCH_EN
        chk("loop_r0",    {16'd0, get_reg(0)}, 32'd0);
        chk("loop_flags", {29'd0, flags}, 32'b011);
`else
        chk("loop_r0",    {16'd0, get_reg(0)}, 32'd2);
        chk("loop_flags", {29'd0, flags}, 32'b001);
`endif
        run = 1'b0;

        // Reset during T4 of a store must suppress the write.
        rst = 1'b1;
        @(negedge clk);
        put(8'd0, enc(mv_, 1, 1, 9'h055));
        put(8'd1, enc(mv_, 1, 2, 9'h020));
        put(8'd2, enc(st_, 0, 1, 9'h002));
        put(8'h20, 16'hDEAD);
        rst = 1'b0;
        run = 1'b1;
        step(cyc, wc, wa, wd);
        chk("rs_mv1_cycles", cyc, 4);
        step(cyc, wc, wa, wd);
        chk("rs_mv2_cycles", cyc, 4);
        saw_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            saw_w |= w;
            @(negedge clk);
        end
        chk("rs_at_t4", {29'd0, dut.r_tstep}, {29'd0, T4});
        rst = 1'b1;
        @(negedge clk);
        saw_w |= w;
        chk("rs_w",     {31'd0, saw_w}, 32'd0);
        chk("rs_done",  {31'd0, done}, 32'd0);
        chk("rs_tstep", {29'd0, dut.r_tstep}, {29'd0, T0});
        chk("rs_pc",    {16'd0, get_reg(7)}, 32'd0);
        chk("rs_r1",    {16'd0, get_reg(1)}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rs_fetch_addr", {16'd0, addr}, 32'd0);
        chk("rs_fetch_pc",   {16'd0, get_reg(7)}, 32'd1);
        chk("rs_mem_kept",   {16'd0, mem[8'h20]}, 32'hDEAD);
        run = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
